// File: rtl/riscv_uart_pkg.sv
// Shared definitions for the RISC-V UART transmitter: FSM encoding, frame
// constants and the baud-counter width helper.
package riscv_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // A divider of 1 still needs a one-bit counter to stay legal.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/riscv_uart_fifo.sv
// Byte FIFO between the LSU store path and the serialiser: synchronous
// push/pop, registered occupancy, power-of-two depth with wrapping pointers.
module riscv_uart_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
  localparam logic [PW:0]   ONE_CNT  = 1;
  localparam logic [PW-1:0] ONE_PTR  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ONE_PTR;
    if (do_pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/riscv_uart_tx.sv
// UART transmitter for the RISC-V LSU: stores land in a byte FIFO and are
// serialised 8N1 at CLK_FREQ/BAUD, with back-to-back frames when data waits.
module riscv_uart_tx
  import riscv_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       i_riscv_uart_clk,
  input  logic       i_riscv_uart_rst,
  input  logic       i_riscv_uart_globstall,
  input  logic       i_riscv_uart_tx_valid,
  input  logic [7:0] i_riscv_uart_tx_data,
  output logic       o_riscv_uart_tx,
  output logic       o_riscv_uart_full,
  output logic       o_riscv_uart_active
);

  localparam int unsigned      DIV      = CLK_FREQ / BAUD;
  localparam int unsigned      CNT_W    = cnt_width(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam int unsigned      FCNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic             push, pop, baud_end;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [FCNT_W-1:0] fifo_count;

  // A stalled pipeline must not commit the store, so stall gates the push only.
  assign push = i_riscv_uart_tx_valid & ~i_riscv_uart_globstall & ~fifo_full;

  riscv_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (i_riscv_uart_clk),
    .rst   (i_riscv_uart_rst),
    .push  (push),
    .pop   (pop),
    .din   (i_riscv_uart_tx_data),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_end            = (cnt_q == CNT_LAST);
  assign o_riscv_uart_tx     = tx_q;
  assign o_riscv_uart_full   = fifo_full;
  assign o_riscv_uart_active = (state_q != IDLE) | (fifo_count != '0);

  // tx_d is the line level for the state being entered, keeping tx registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (baud_end) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (baud_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_riscv_uart_clk) begin
    if (i_riscv_uart_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_riscv_uart_tx.sv
// Randomised bench for riscv_uart_tx: a queue/arithmetic reference model
// predicts the line every cycle and a serial decoder checks the byte order.
module tb_riscv_uart_tx;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 5_000_000;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned FRAME    = 10 * DIV;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       stall = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       tx, full, active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_riscv_uart_clk       (clk),
    .i_riscv_uart_rst       (rst),
    .i_riscv_uart_globstall (stall),
    .i_riscv_uart_tx_valid  (valid),
    .i_riscv_uart_tx_data   (data),
    .o_riscv_uart_tx        (tx),
    .o_riscv_uart_full      (full),
    .o_riscv_uart_active    (active)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: bytes waiting, cycles left in the current frame, and the
  // byte being sent; the line level follows from position within the frame.
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  int         frame_left  = 0;
  logic [7:0] cur_byte    = 8'h00;
  bit         model_on    = 1'b0;
  bit         last_accept = 1'b0;

  function automatic logic expTx();
    int p, b;
    if (frame_left == 0) return 1'b1;
    p = FRAME - frame_left;
    b = p / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur_byte[b-1];
  endfunction

  always @(posedge clk) begin
    bit do_pop, do_push;
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      frame_left  = 0;
      model_on    = 1'b1;
      last_accept = 1'b0;
    end else begin
      if (frame_left > 0) frame_left--;
      do_pop  = (frame_left == 0) && (model_q.size() > 0);
      do_push = valid && !stall && (model_q.size() < DEPTH);
      if (do_pop) begin
        cur_byte   = model_q.pop_front();
        frame_left = FRAME;
      end
      if (do_push) begin
        model_q.push_back(data);
        exp_q.push_back(data);
      end
      last_accept = do_push;
    end
  end

  // Per-cycle line/flag comparison plus a mid-bit sampling decoder.
  int         dec_pos = -1;
  int         dec_bit = 0;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("tx_line", tx, expTx());
      checkOutput("full", full, model_q.size() == DEPTH);
      checkOutput("active", active, (frame_left > 0) || (model_q.size() > 0));
      if (rst) dec_pos = -1;
      else if (dec_pos < 0) begin
        if (tx === 1'b0) dec_pos = 0;
      end else dec_pos++;
      if (dec_pos >= 0 && (dec_pos % DIV) == DIV / 2) begin
        dec_bit = dec_pos / DIV;
        if (dec_bit == 0) checkOutput("start_bit", tx, 0);
        else if (dec_bit <= 8) dec_byte[dec_bit-1] = tx;
        else begin
          checkOutput("stop_bit", tx, 1);
          checkOutput("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) checkOutput("rx_byte", dec_byte, exp_q.pop_front());
        end
      end
      if (dec_pos == FRAME - 1) dec_pos = -1;
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic s,
                               input logic r);
    valid = v;
    data  = d;
    stall = s;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (active !== 1'b0 && n < budget) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("drain_active", active, 0);
    checkOutput("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_active", active, 0);

    $display("[TB] single byte 0xA5");
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("latency_pre", tx, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("latency_start", tx, 0);
    waitIdle(300);

    $display("[TB] back-to-back 0x00 0xFF");
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    waitIdle(400);

    $display("[TB] fill and hold while full");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    checkOutput("fill_full", full, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
      checkOutput("hold_full", full, 1);
    end
    waitIdle(1500);

    $display("[TB] stall gating");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0);
      checkOutput("stall_tx", tx, 1);
      checkOutput("stall_active", active, 0);
    end
    waitIdle(50);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h96, 1'b0, 1'b0);
    repeat (43) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_full", full, 0);
    repeat (150) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_quiet_tx", tx, 1);
    waitIdle(10);

    $display("[TB] wrap stream 0x00..0x13");
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 25)) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      n = 0;
      do begin
        applyStimulus(1'b1, 8'(i), $urandom_range(0, 3) == 0, 1'b0);
        n++;
      end while (!last_accept && n < 2000);
    end
    waitIdle(2500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
